sram_2port: RTL and testbench

Generic two-port synchronous SRAM macro model: one dedicated read port (A) and one dedicated write port (B), each on its own clock. It backs the LED display driver's frame buffer. The 512x16 instance holds one full frame of 16-bit grey levels. The 256x16 instance caches the partial frame used by the driver's dual-field mode. Both fixed-size macros, `sram_512x16` and `sram_256x16`, are this block with parameters set.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_256x16.sv | 33 +++
 rtl/sram_512x16.sv | 33 +++
 rtl/sram_2port.sv | 93 +++++++++
 tb/tb_sram_2port.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the LED display driver's frame buffer SRAM macros.
//   SRAM_W      : data bits per word for every frame buffer macro
//   FRAME_DEPTH : words in the full-frame buffer
//   CACHE_DEPTH : words in the dual-field partial-frame cache
//   FRAME_AW    : address width of the full-frame buffer
//   CACHE_AW    : address width of the partial-frame cache
package sram_pkg;

    localparam int SRAM_W      = 16;
    localparam int FRAME_DEPTH = 512;
    localparam int CACHE_DEPTH = 256;
    localparam int FRAME_AW    = $clog2(FRAME_DEPTH);
    localparam int CACHE_AW    = $clog2(CACHE_DEPTH);

endpackage

// File: rtl/sram_256x16.sv
// Partial-frame cache macro for dual-field mode: 256 words of 16 bits.
// Ports as sram_2port with an 8-bit address.
module sram_256x16
    import sram_pkg::*;
(
    input  logic                CLKA,
    input  logic                CLKB,
    input  logic                rst,
    input  logic                CENA,
    input  logic [CACHE_AW-1:0] AA,
    output logic [SRAM_W-1:0]   QA,
    input  logic                CENB,
    input  logic [CACHE_AW-1:0] AB,
    input  logic [SRAM_W-1:0]   DB
);

    sram_2port #(
        .DEPTH (CACHE_DEPTH),
        .WIDTH (SRAM_W),
        .AW    (CACHE_AW)
    ) u_sram (
        .CLKA (CLKA),
        .CLKB (CLKB),
        .rst  (rst),
        .CENA (CENA),
        .AA   (AA),
        .QA   (QA),
        .CENB (CENB),
        .AB   (AB),
        .DB   (DB)
    );

endmodule

// File: rtl/sram_512x16.sv
// Full-frame buffer macro: 512 words of 16-bit grey levels.
// Ports as sram_2port with a 9-bit address.
module sram_512x16
    import sram_pkg::*;
(
    input  logic                CLKA,
    input  logic                CLKB,
    input  logic                rst,
    input  logic                CENA,
    input  logic [FRAME_AW-1:0] AA,
    output logic [SRAM_W-1:0]   QA,
    input  logic                CENB,
    input  logic [FRAME_AW-1:0] AB,
    input  logic [SRAM_W-1:0]   DB
);

    sram_2port #(
        .DEPTH (FRAME_DEPTH),
        .WIDTH (SRAM_W),
        .AW    (FRAME_AW)
    ) u_sram (
        .CLKA (CLKA),
        .CLKB (CLKB),
        .rst  (rst),
        .CENA (CENA),
        .AA   (AA),
        .QA   (QA),
        .CENB (CENB),
        .AB   (AB),
        .DB   (DB)
    );

endmodule

// File: rtl/sram_2port.sv
// Generic two-port synchronous SRAM model: one read port (A) and one
// write port (B), each on its own rising-edge clock.
// Parameters:
//   DEPTH : number of words (power of two, 256 or 512)
//   WIDTH : data bits per word
//   AW    : address width, log2(DEPTH)
// Ports:
//   CLKA  : read clock
//   CLKB  : write clock, asynchronous to CLKA
//   rst   : asynchronous active-high reset of the read register only
//   CENA  : read enable, active-low
//   AA    : read address
//   QA    : registered read data
//   CENB  : write enable, active-low
//   AB    : write address
//   DB    : write data
module sram_2port
    import sram_pkg::*;
#(
    parameter int DEPTH = FRAME_DEPTH,
    parameter int WIDTH = SRAM_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLKA,
    input  logic             CLKB,
    input  logic             rst,
    input  logic             CENA,
    input  logic [AW-1:0]    AA,
    output logic [WIDTH-1:0] QA,
    input  logic             CENB,
    input  logic [AW-1:0]    AB,
    input  logic [WIDTH-1:0] DB
);

    // Storage is deliberately never reset; unwritten words stay unknown.
    logic [WIDTH-1:0] mem [DEPTH];

    // Address/enable qualification. In synthesis the address is always
    // known and the enable is always 0 or 1, so these collapse to constants.
    logic addr_known;
    logic cen_corrupt;

    always_comb begin
        addr_known  = 1'b1;
        cen_corrupt = 1'b0;
`ifndef SYNTHESIS
        addr_known  = !$isunknown(AB);
        cen_corrupt = $isunknown(CENB) && !$isunknown(AB);
`endif
    end

    // Read register. Non-blocking update against the same-timestep write
    // means a colliding read returns the old word.
    always_ff @(posedge CLKA or posedge rst) begin
        if (rst) begin
            QA <= '0;
        end else if (!CENA) begin
            QA <= mem[AA];
        end
    end

    // Write port. A write coinciding with reset is dropped; an unknown
    // enable with a known address poisons the addressed word.
    always_ff @(posedge CLKB) begin
        if (!rst) begin
            if (CENB == 1'b0) begin
                if (addr_known) begin
                    mem[AB] <= DB;
                end
            end else if (cen_corrupt) begin
                mem[AB] <= 'x;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only diagnostics for writes that cannot be honoured.
    always @(posedge CLKB) begin
        if (!rst && CENB == 1'b0 && $isunknown(AB)) begin
            $warning("sram_2port: write with unknown address ignored");
        end
        if (!rst && cen_corrupt) begin
            $warning("sram_2port: unknown write enable, word corrupted");
        end
    end

    // Parameter sanity check at elaboration.
    if (DEPTH != 256 && DEPTH != 512) begin : g_bad_depth
        $error("sram_2port: DEPTH must be 256 or 512");
    end
`endif

endmodule

// File: tb/tb_sram_2port.sv
// Testbench for sram_2port: a 512-word instance with aligned read/write
// clocks (for collision cases) and a 256-word instance with unrelated
// 7 ns / 10 ns clocks.
`timescale 1ns/100ps
module tb_sram_2port;

    // Shared reset
    logic rst;

    // 512-word instance, both clocks 10 ns and rising together
    logic        clka1, clkb1;
    logic        cena1, cenb1;
    logic [8:0]  aa1, ab1;
    logic [15:0] db1, qa1;

    // 256-word instance, CLKB 7 ns, CLKA 10 ns
    logic        clka2, clkb2;
    logic        cena2, cenb2;
    logic [7:0]  aa2, ab2;
    logic [15:0] db2, qa2;

    int tests_run;
    int tests_failed;

    sram_2port #(.DEPTH(512), .WIDTH(16)) u_dut512 (
        .CLKA (clka1),
        .CLKB (clkb1),
        .rst  (rst),
        .CENA (cena1),
        .AA   (aa1),
        .QA   (qa1),
        .CENB (cenb1),
        .AB   (ab1),
        .DB   (db1)
    );

    sram_2port #(.DEPTH(256), .WIDTH(16)) u_dut256 (
        .CLKA (clka2),
        .CLKB (clkb2),
        .rst  (rst),
        .CENA (cena2),
        .AA   (aa2),
        .QA   (qa2),
        .CENB (cenb2),
        .AB   (ab2),
        .DB   (db2)
    );

    initial begin
        clka1 = 1'b0;
        clkb1 = 1'b0;
        clka2 = 1'b0;
        clkb2 = 1'b0;
    end
    always #5   clka1 = ~clka1;
    always #5   clkb1 = ~clkb1;
    always #5   clka2 = ~clka2;
    always #3.5 clkb2 = ~clkb2;

    // One cycle of stimulus on the 512-word instance
    typedef struct {
        string       name;
        logic        wr;
        logic [8:0]  wa;
        logic [15:0] wd;
        logic        rd;
        logic [8:0]  ra;
        logic        chk;
        logic [15:0] exp_qa;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: QA=%h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clka1);
        cenb1 = ~v.wr;
        ab1   = v.wa;
        db1   = v.wd;
        cena1 = ~v.rd;
        aa1   = v.ra;
        @(posedge clka1);
        #1;
        if (v.chk) checkOutput(v.name, qa1, v.exp_qa);
    endtask

    task automatic addVec(input string name, input logic wr, input logic [8:0] wa,
                          input logic [15:0] wd, input logic rd, input logic [8:0] ra,
                          input logic chk, input logic [15:0] exp_qa);
        vec_t v;
        v.name = name; v.wr = wr; v.wa = wa; v.wd = wd;
        v.rd = rd; v.ra = ra; v.chk = chk; v.exp_qa = exp_qa;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b0;
        cena1 = 1'b1; cenb1 = 1'b1; aa1 = '0; ab1 = '0; db1 = '0;
        cena2 = 1'b1; cenb2 = 1'b1; aa2 = '0; ab2 = '0; db2 = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_qa512", qa1, 16'h0000);
        checkOutput("reset_qa256", qa2, 16'h0000);
        repeat (2) @(posedge clka1);
        @(negedge clka1);
        rst = 1'b0;

        // name, wr, wa, wd, rd, ra, chk, exp
        addVec("wr_1ff",        1, 9'h1FF, 16'hA5A5, 0, 9'h000, 0, 16'h0000);
        addVec("wr_000",        1, 9'h000, 16'h0001, 0, 9'h000, 0, 16'h0000);
        addVec("wr_005",        1, 9'h005, 16'h1234, 0, 9'h000, 0, 16'h0000);
        addVec("wr_007",        1, 9'h007, 16'h1111, 0, 9'h000, 0, 16'h0000);
        addVec("rd_1ff",        0, 9'h000, 16'h0000, 1, 9'h1FF, 1, 16'hA5A5);
        addVec("rd_000",        0, 9'h000, 16'h0000, 1, 9'h000, 1, 16'h0001);
        addVec("cena_hold",     0, 9'h000, 16'h0000, 0, 9'h1FF, 1, 16'h0001);
        addVec("cenb_off_rd5",  0, 9'h005, 16'hFFFF, 1, 9'h005, 1, 16'h1234);
        addVec("cenb_off_rd5b", 0, 9'h005, 16'hFFFF, 1, 9'h005, 1, 16'h1234);
        addVec("collide_old",   1, 9'h007, 16'h2222, 1, 9'h007, 1, 16'h1111);
        addVec("collide_new",   0, 9'h000, 16'h0000, 1, 9'h007, 1, 16'h2222);
        addVec("wr_a_rd_1ff",   1, 9'h00A, 16'hBEEF, 1, 9'h1FF, 1, 16'hA5A5);
        addVec("rd_00a",        0, 9'h000, 16'h0000, 1, 9'h00A, 1, 16'hBEEF);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset pulse between edges clears QA at once
        @(negedge clka1);
        cena1 = 1'b1;
        cenb1 = 1'b1;
        #2 rst = 1'b1;
        #1 checkOutput("rst_async", qa1, 16'h0000);
        #1 rst = 1'b0;
        @(posedge clka1);
        #1 checkOutput("rst_idle_hold", qa1, 16'h0000);

        // Reset held across an edge with both ports enabled: QA stays 0,
        // and the write of 0 to address 10 is dropped.
        @(negedge clka1);
        rst   = 1'b1;
        cena1 = 1'b0; aa1 = 9'h00A;
        cenb1 = 1'b0; ab1 = 9'h00A; db1 = 16'h0000;
        @(posedge clka1);
        #1 checkOutput("rst_hold_read", qa1, 16'h0000);
        @(negedge clka1);
        rst   = 1'b0;
        cenb1 = 1'b1;
        @(posedge clka1);
        #1 checkOutput("after_rst_preserved", qa1, 16'hBEEF);

        // Unknown write address: only meaningful on a four-state simulator
        @(negedge clka1);
        ab1 = 'x;
        db1 = 16'hDEAD;
        if ($isunknown(ab1)) begin
            cenb1 = 1'b0;
            @(negedge clka1);
            cenb1 = 1'b1;
            ab1   = '0;
            cena1 = 1'b0; aa1 = 9'h007;
            @(posedge clka1);
            #1 checkOutput("xaddr_keep7", qa1, 16'h2222);
            @(negedge clka1); aa1 = 9'h1FF;
            @(posedge clka1);
            #1 checkOutput("xaddr_keep1ff", qa1, 16'hA5A5);
        end
        @(negedge clka1);
        cena1 = 1'b1;
        cenb1 = 1'b1;
        ab1   = '0;

        // Independent clocks on the 256-word instance
        for (int i = 0; i < 256; i++) begin
            @(negedge clkb2);
            cenb2 = 1'b0;
            ab2   = 8'(i);
            db2   = 16'(i * 3);
        end
        @(negedge clkb2);
        cenb2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clka2);
            cena2 = 1'b0;
            aa2   = 8'(i);
            @(posedge clka2);
            #1 checkOutput($sformatf("readback_%0d", i), qa2, 16'(i * 3));
        end
        @(negedge clka2);
        cena2 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
